mem_req_initiator: RTL and testbench
====================================

# mem_req_initiator

- Sits between the L2 cache miss path and the block-wide main memory port.
- Accepts one miss request at a time, with an optional dirty-victim writeback.
- Sequences the writeback write and the fill read toward memory, and waits out the ~100-cycle read latency.
- Returns the filled block to L2 through a valid/ready response channel, with timeout-based error reporting.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, word-address width
- BLOCK_SIZE, 16, words per block; power of two; BLOCK_BITS = $clog2(BLOCK_SIZE)
- TIMEOUT_CYCLES, 256, max RD_WAIT cycles before error; must be ≥ 2

Ports (blocks are packed [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]):
- clk  in  1  clock; one clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  L2 miss request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  miss address; any word in the block
- req_wb  in  1  victim is dirty; write it back first
- req_wb_addr  in  ADDR_WIDTH  victim address
- req_wb_data  in  block  victim block
- resp_valid  out  1  fill response present
- resp_ready  in  1  L2 accepts response
- resp_addr  out  ADDR_WIDTH  block-aligned fill address
- resp_data  out  block  fill data
- resp_err  out  1  fill failed (timeout or no-hit); resp_data is 0
- mem_addr  out  ADDR_WIDTH  block-aligned memory address
- mem_data_out  out  block  write data to memory
- mem_data_in  in  block  read data from memory
- mem_read  out  1  read command pulse
- mem_write  out  1  write command pulse
- mem_hit  in  1  memory data valid
- mem_ready  in  1  memory read complete

## Operation
- All addresses driven out are aligned: {addr[ADDR_WIDTH-1:BLOCK_BITS], BLOCK_BITS'b0}.
- The block registers captured values at acceptance; input changes afterwards have no effect.
- IDLE: req_ready=1; all mem_* commands low.
  - On req_valid&&req_ready, capture the aligned req_addr, req_wb, the aligned req_wb_addr and req_wb_data.
  - Go to WB if req_wb is set, else go to RD_ISSUE.
- WB: one cycle with mem_write=1, mem_addr=victim address, mem_data_out=victim data; then RD_ISSUE. No write acknowledge exists; the write is complete after this cycle.
- RD_ISSUE: one cycle with mem_read=1, mem_addr=fill address; clear the timeout counter; then RD_WAIT.
  - mem_read is strictly a single-cycle pulse. Holding it high would restart a read in memory after mem_ready.
- RD_WAIT: mem_read=0; mem_addr is held.
  - mem_ready&&mem_hit: register mem_data_in into resp_data, resp_err=0, go to RESP.
  - mem_ready&&!mem_hit: resp_data=0, resp_err=1, go to RESP.
  - Otherwise increment the counter. With timeout enabled, a counter value of TIMEOUT_CYCLES-1 without mem_ready gives resp_err=1, resp_data=0, then RESP.
- RESP: resp_valid=1; resp_addr, resp_data and resp_err are stable until resp_valid&&resp_ready, then IDLE.
- mem_ready/mem_hit arriving outside RD_WAIT are ignored.
- mem_data_out holds its last value when mem_write=0.

## Timing
- Reset values: req_ready=0 while rst is high, 1 on the first cycle after; all other outputs 0; mem_addr=0; mem_data_out=0; state=IDLE; counter=0.
- rst during any state, including RD_WAIT and RESP, aborts the transaction in one edge. No response is produced.
- Accept edge E0, no writeback: mem_read is high during the cycle after E0.
- Against the 100-cycle memory: mem_ready is sampled at E0+101; resp_valid is high from E0+101.
- A writeback adds exactly 1 cycle.
- Earliest new accept: the edge after the resp handshake. The block has no back-to-back overlap and at most one transaction in flight.
- resp_valid held with resp_ready=0 stalls indefinitely; req_ready stays 0 during the stall.

## Configuration
- MEM_REQ_TIMEOUT_EN defined: the RD_WAIT counter and timeout error path are present, as above.
- MEM_REQ_TIMEOUT_EN undefined:
  - The counter logic is removed and RD_WAIT waits forever for mem_ready.
  - resp_err is asserted only on mem_ready&&!mem_hit.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Reset with memory holding mem[i]=i; req 0x43, no wb:
  - required: mem_read one-cycle pulse with mem_addr=0x40;
  - required: resp_valid at accept+101, resp_addr=0x40, resp_data words 0x40..0x4F, resp_err=0.
- Req 0x105 with req_wb=1, wb_addr 0x2F, wb_data all 0xA5A5A5A5:
  - required: mem_write pulse at 0x20 carrying that data, then a mem_read pulse at 0x100 on the next cycle;
  - required: response at accept+102.
- Hold resp_ready=0 for 20 cycles after resp_valid:
  - required: outputs stable, req_ready=0, second req_valid not accepted;
  - required: after the handshake, the next accept occurs on the following edge.
- MEM_REQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, memory never readies:
  - required: resp_err=1, resp_data=0 at accept+2+15;
  - required: a later stray mem_ready in IDLE is ignored.
- Memory returns mem_ready=1 with mem_hit=0 -> resp_err=1, resp_data=0.
- Assert rst 50 cycles into RD_WAIT:
  - required: every output at its reset value the next cycle, no resp_valid;
  - required: a fresh req 0x80 afterwards completes normally with data 0x80..0x8F.

Source files
------------

// File: rtl/mem_req_initiator_if.sv
// Bus interfaces for mem_req_initiator.
//   l2_req_if   : L2 miss request / fill response channel (L2 is master).
//   mem_port_if : block-wide main-memory command port (initiator is master).
// Blocks are packed [BLOCK_SIZE-1:0][DATA_WIDTH-1:0], word 0 in the low bits.

interface l2_req_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 16
);
  // Miss request
  logic                                  req_valid;
  logic                                  req_ready;
  logic [ADDR_WIDTH-1:0]                 req_addr;
  logic                                  req_wb;
  logic [ADDR_WIDTH-1:0]                 req_wb_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_wb_data;

  // Fill response
  logic                                  resp_valid;
  logic                                  resp_ready;
  logic [ADDR_WIDTH-1:0]                 resp_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] resp_data;
  logic                                  resp_err;

  // L2 side
  modport master (
    output req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_data, resp_err
  );

  // Initiator side
  modport slave (
    input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_data, resp_err
  );
endinterface

interface mem_port_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 16
);
  logic [ADDR_WIDTH-1:0]                 mem_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in;
  logic                                  mem_read;
  logic                                  mem_write;
  logic                                  mem_hit;
  logic                                  mem_ready;

  // Initiator side
  modport master (
    output mem_addr, mem_data_out, mem_read, mem_write,
    input  mem_data_in, mem_hit, mem_ready
  );

  // Memory side
  modport slave (
    input  mem_addr, mem_data_out, mem_read, mem_write,
    output mem_data_in, mem_hit, mem_ready
  );
endinterface

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: sequences one L2 miss at a time toward block-wide main
// memory -- optional dirty-victim write, single-cycle read command, wait for
// the long read latency, then a valid/ready fill response back to L2.
// Optional feature macro: MEM_REQ_TIMEOUT_EN adds a read-wait timeout counter
// (TIMEOUT_CYCLES) that returns an error response if memory never readies.
// All outputs are registered; reset is synchronous, active-high.

module mem_req_initiator #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned BLOCK_SIZE     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  l2_req_if.slave    l2,
  mem_port_if.master mem
);

  localparam int unsigned BLOCK_BITS = $clog2(BLOCK_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << BLOCK_BITS) - ADDR_WIDTH'(1));

  typedef logic [ADDR_WIDTH-1:0]                 addr_t;
  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RESP
  } state_t;

  // Elaboration-time guard on the timeout range
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("mem_req_initiator: TIMEOUT_CYCLES must be at least 2");
  end

  // Block-align an address by clearing the word-offset bits
  function automatic addr_t align(input addr_t a);
    return a & ALIGN_MASK;
  endfunction

  state_t state;
  state_t state_next;

  // Fill address captured at acceptance; victim address/data go straight
  // into the registered memory outputs, so they need no separate copy.
  addr_t  fill_addr;
  addr_t  fill_addr_next;

  logic   req_ready_next;
  logic   resp_valid_next;
  addr_t  resp_addr_next;
  block_t resp_data_next;
  logic   resp_err_next;
  addr_t  mem_addr_next;
  block_t mem_data_out_next;
  logic   mem_read_next;
  logic   mem_write_next;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_next        = state;
    fill_addr_next    = fill_addr;
    req_ready_next    = 1'b0;
    resp_valid_next   = 1'b0;
    resp_addr_next    = l2.resp_addr;
    resp_data_next    = l2.resp_data;
    resp_err_next     = l2.resp_err;
    mem_addr_next     = mem.mem_addr;
    mem_data_out_next = mem.mem_data_out;
    mem_read_next     = 1'b0;
    mem_write_next    = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    cnt_next          = cnt;
`endif

    case (state)
      S_IDLE: begin
        req_ready_next = 1'b1;
        if (l2.req_valid && l2.req_ready) begin
          req_ready_next = 1'b0;
          fill_addr_next = align(l2.req_addr);
          if (l2.req_wb) begin
            // Victim write goes out in the very next cycle
            state_next        = S_WB;
            mem_write_next    = 1'b1;
            mem_addr_next     = align(l2.req_wb_addr);
            mem_data_out_next = l2.req_wb_data;
          end else begin
            state_next    = S_RD_ISSUE;
            mem_read_next = 1'b1;
            mem_addr_next = align(l2.req_addr);
          end
        end
      end

      S_WB: begin
        // No write acknowledge: the read follows immediately
        state_next    = S_RD_ISSUE;
        mem_read_next = 1'b1;
        mem_addr_next = fill_addr;
      end

      S_RD_ISSUE: begin
        // mem_read drops after one cycle; a held read would restart memory
        state_next = S_RD_WAIT;
`ifdef MEM_REQ_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end

      S_RD_WAIT: begin
        if (mem.mem_ready) begin
          state_next      = S_RESP;
          resp_valid_next = 1'b1;
          resp_addr_next  = fill_addr;
          resp_err_next   = !mem.mem_hit;
          resp_data_next  = mem.mem_hit ? mem.mem_data_in : '0;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          state_next      = S_RESP;
          resp_valid_next = 1'b1;
          resp_addr_next  = fill_addr;
          resp_err_next   = 1'b1;
          resp_data_next  = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        // Response payload holds until L2 takes it
        resp_valid_next = 1'b1;
        if (l2.resp_valid && l2.resp_ready) begin
          state_next      = S_IDLE;
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      fill_addr        <= '0;
      l2.req_ready     <= 1'b0;
      l2.resp_valid    <= 1'b0;
      l2.resp_addr     <= '0;
      l2.resp_data     <= '0;
      l2.resp_err      <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_data_out <= '0;
      mem.mem_read     <= 1'b0;
      mem.mem_write    <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
      cnt              <= '0;
`endif
    end else begin
      state            <= state_next;
      fill_addr        <= fill_addr_next;
      l2.req_ready     <= req_ready_next;
      l2.resp_valid    <= resp_valid_next;
      l2.resp_addr     <= resp_addr_next;
      l2.resp_data     <= resp_data_next;
      l2.resp_err      <= resp_err_next;
      mem.mem_addr     <= mem_addr_next;
      mem.mem_data_out <= mem_data_out_next;
      mem.mem_read     <= mem_read_next;
      mem.mem_write    <= mem_write_next;
`ifdef MEM_REQ_TIMEOUT_EN
      cnt              <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Self-checking bench for mem_req_initiator: directed vector table, random
// transactions against a block-level reference model, and hand sequences for
// stall, stray memory strobes, timeout (MEM_REQ_TIMEOUT_EN) and mid-read reset.

module tb_mem_req_initiator;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BS = 16;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam int unsigned TO  = 16;
  localparam int          LAT = 10;
`else
  localparam int unsigned TO  = 256;
  localparam int          LAT = 100;
`endif
  localparam int BUDGET   = LAT + int'(TO) + 20;
  localparam int RST_WAIT = LAT / 2;
  localparam int HIT      = 0;
  localparam int MISS     = 1;
  localparam int NEVER    = 2;

  typedef logic [BS-1:0][DW-1:0] blk_t;

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    logic          wb;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_word;
    int            mode;
    int            hold;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_wb_addr;
    logic          exp_err;
    int            exp_k;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   mem_mode;
  logic stray;

  l2_req_if   #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) l2_bus ();
  mem_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) mem_bus ();

  mem_req_initiator #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BLOCK_SIZE    (BS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .l2 (l2_bus),
    .mem(mem_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~AW'(BS - 1);
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < int'(BS); i++) b[i] = $urandom;
    return b;
  endfunction

  // Reference: a good fill returns words base..base+BS-1; errors return zero
  function automatic blk_t model_block(input logic [AW-1:0] base, input logic err);
    blk_t b;
    b = '0;
    if (!err)
      for (int i = 0; i < int'(BS); i++) b[i] = DW'(base + AW'(i));
    return b;
  endfunction

  function automatic vec_t mk(input string n, input logic [AW-1:0] a, input logic wb,
                              input logic [AW-1:0] wa, input logic [DW-1:0] ww,
                              input int md, input int hold, input logic [AW-1:0] ea,
                              input logic [AW-1:0] ewa, input logic ee, input int ek);
    vec_t v;
    v.name = n; v.addr = a; v.wb = wb; v.wb_addr = wa; v.wb_word = ww;
    v.mode = md; v.hold = hold; v.exp_addr = ea; v.exp_wb_addr = ewa;
    v.exp_err = ee; v.exp_k = ek;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input blk_t act, input blk_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: identity contents (word at address a holds a); a read
  // command seen in a cycle produces mem_ready LAT cycles later.
  initial begin
    int            cd;
    logic [AW-1:0] base;
    cd   = 0;
    base = '0;
    mem_bus.mem_ready   = 1'b0;
    mem_bus.mem_hit     = 1'b0;
    mem_bus.mem_data_in = '0;
    forever begin
      @(negedge clk);
      mem_bus.mem_ready   = stray;
      mem_bus.mem_hit     = stray;
      mem_bus.mem_data_in = rand_blk();
      if (rst) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            mem_bus.mem_ready = 1'b1;
            mem_bus.mem_hit   = (mem_mode == HIT);
            if (mem_mode == HIT)
              for (int i = 0; i < int'(BS); i++) mem_bus.mem_data_in[i] = DW'(base + AW'(i));
          end
        end
        if (mem_bus.mem_read && mem_mode != NEVER) begin
          cd   = LAT;
          base = mem_bus.mem_addr;
        end
      end
    end
  end

  // One full transaction; entered and left just after a falling edge
  task automatic run_txn(input vec_t v);
    int            nr, nw, rk, wk, rv_k;
    logic [AW-1:0] raddr, waddr, r_addr;
    blk_t          wdata, rdout, r_data, wb_blk;
    logic          r_err;
    logic          stable;

    for (int i = 0; i < int'(BS); i++) wb_blk[i] = v.wb_word;
    mem_mode = v.mode;
    l2_bus.req_valid   = 1'b1;
    l2_bus.req_addr    = v.addr;
    l2_bus.req_wb      = v.wb;
    l2_bus.req_wb_addr = v.wb_addr;
    l2_bus.req_wb_data = wb_blk;
    l2_bus.resp_ready  = 1'b0;
    chk({v.name, ":req_ready"}, 64'(l2_bus.req_ready), 64'(1));

    @(posedge clk);
    @(negedge clk);
    // Captured values must not track later input changes
    l2_bus.req_valid   = 1'b0;
    l2_bus.req_addr    = $urandom;
    l2_bus.req_wb      = 1'($urandom);
    l2_bus.req_wb_addr = $urandom;
    l2_bus.req_wb_data = rand_blk();

    nr = 0; nw = 0; rk = -1; wk = -1; rv_k = -1;
    raddr = '0; waddr = '0; wdata = '0; rdout = '0;
    for (int k = 1; k <= BUDGET; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_bus.mem_write) begin
        nw++; wk = k; waddr = mem_bus.mem_addr; wdata = mem_bus.mem_data_out;
      end
      if (mem_bus.mem_read) begin
        nr++; rk = k; raddr = mem_bus.mem_addr; rdout = mem_bus.mem_data_out;
      end
      if (l2_bus.resp_valid) begin
        rv_k = k;
        break;
      end
    end

    chk({v.name, ":resp_cycle"}, 64'(rv_k), 64'(v.exp_k));
    chk({v.name, ":rd_pulses"},  64'(nr), 64'(1));
    chk({v.name, ":rd_cycle"},   64'(rk), 64'(v.wb ? 2 : 1));
    chk({v.name, ":rd_addr"},    64'(raddr), 64'(v.exp_addr));
    chk({v.name, ":wr_pulses"},  64'(nw), 64'(v.wb ? 1 : 0));
    if (v.wb) begin
      chk({v.name, ":wr_cycle"}, 64'(wk), 64'(1));
      chk({v.name, ":wr_addr"},  64'(waddr), 64'(v.exp_wb_addr));
      chk_blk({v.name, ":wr_data"}, wdata, wb_blk);
      chk_blk({v.name, ":data_out_held"}, rdout, wb_blk);
    end
    chk({v.name, ":resp_addr"}, 64'(l2_bus.resp_addr), 64'(v.exp_addr));
    chk_blk({v.name, ":resp_data"}, l2_bus.resp_data, model_block(v.exp_addr, v.exp_err));
    chk({v.name, ":resp_err"}, 64'(l2_bus.resp_err), 64'(v.exp_err));
    chk({v.name, ":req_ready_busy"}, 64'(l2_bus.req_ready), 64'(0));

    // Optional stall with a competing request held on the bus
    r_addr = l2_bus.resp_addr;
    r_data = l2_bus.resp_data;
    r_err  = l2_bus.resp_err;
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      l2_bus.req_valid = 1'b1;
      l2_bus.req_addr  = 32'h0000_0BAD;
      @(negedge clk);
      if (!l2_bus.resp_valid || l2_bus.resp_addr !== r_addr || l2_bus.resp_data !== r_data ||
          l2_bus.resp_err !== r_err || l2_bus.req_ready !== 1'b0 ||
          mem_bus.mem_read || mem_bus.mem_write)
        stable = 1'b0;
    end
    if (v.hold > 0) chk({v.name, ":stall_stable"}, 64'(stable), 64'(1));

    l2_bus.req_valid  = 1'b0;
    l2_bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l2_bus.resp_ready = 1'b0;
    chk({v.name, ":resp_done"}, 64'(l2_bus.resp_valid), 64'(0));
    chk({v.name, ":req_ready_after"}, 64'(l2_bus.req_ready), 64'(1));
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    logic quiet;

    errors = 0;
    checks = 0;
    mem_mode = HIT;
    stray = 1'b0;
    rst = 1'b1;
    l2_bus.req_valid   = 1'b0;
    l2_bus.req_addr    = '0;
    l2_bus.req_wb      = 1'b0;
    l2_bus.req_wb_addr = '0;
    l2_bus.req_wb_data = '0;
    l2_bus.resp_ready  = 1'b0;

    //            name        addr          wb  wb_addr     wb_word        mode  hold exp_addr      exp_wb_addr  err  resp cycle
    vecs[0] = mk("basic",    32'h43,        0, 32'h0,      32'h0,         HIT,  0,  32'h40,       32'h0,       0,   LAT + 2);
    vecs[1] = mk("wb_stall", 32'h105,       1, 32'h2F,     32'hA5A5A5A5,  HIT,  20, 32'h100,      32'h20,      0,   LAT + 3);
    vecs[2] = mk("top_word", 32'h3CF,       0, 32'h0,      32'h0,         HIT,  0,  32'h3C0,      32'h0,       0,   LAT + 2);
    vecs[3] = mk("miss",     32'h55,        0, 32'h0,      32'h0,         MISS, 2,  32'h50,       32'h0,       1,   LAT + 2);
    vecs[4] = mk("wb_miss",  32'hFFFFFFF3,  1, 32'h9999,   32'h12345678,  MISS, 0,  32'hFFFFFFF0, 32'h9990,    1,   LAT + 3);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst:req_ready",  64'(l2_bus.req_ready),  64'(0));
    chk("rst:resp_valid", 64'(l2_bus.resp_valid), 64'(0));
    chk("rst:mem_read",   64'(mem_bus.mem_read),  64'(0));
    chk("rst:mem_write",  64'(mem_bus.mem_write), 64'(0));
    chk("rst:mem_addr",   64'(mem_bus.mem_addr),  64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst:req_ready_release", 64'(l2_bus.req_ready), 64'(1));

    // Directed vectors
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Random transactions against the reference model
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] a, wa;
      logic          wbr;
      int            md;
      a   = $urandom;
      wa  = $urandom;
      wbr = 1'($urandom);
      md  = int'($urandom_range(0, 1));
      v = mk("rand", a, wbr, wa, $urandom, md, int'($urandom_range(0, 3)),
             align(a), align(wa), (md == MISS), LAT + 2 + (wbr ? 1 : 0));
      run_txn(v);
    end

`ifdef MEM_REQ_TIMEOUT_EN
    // Memory never answers: error response after TIMEOUT_CYCLES wait cycles
    v = mk("timeout", 32'h333, 0, 32'h0, 32'h0, NEVER, 0, 32'h330, 32'h0, 1, int'(TO) + 2);
    run_txn(v);
`endif

    // Stray memory strobes in IDLE are ignored
    mem_mode = HIT;
    stray = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) stray = 1'b0;
      @(negedge clk);
      if (l2_bus.resp_valid || mem_bus.mem_read || mem_bus.mem_write || !l2_bus.req_ready)
        quiet = 1'b0;
    end
    chk("stray:ignored", 64'(quiet), 64'(1));
    v = mk("post_stray", 32'h1234, 0, 32'h0, 32'h0, HIT, 0, 32'h1230, 32'h0, 0, LAT + 2);
    run_txn(v);

    // Reset in the middle of the read wait aborts the transaction
    mem_mode = HIT;
    l2_bus.req_valid = 1'b1;
    l2_bus.req_addr  = 32'h200;
    l2_bus.req_wb    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    l2_bus.req_valid = 1'b0;
    repeat (RST_WAIT) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort:req_ready",    64'(l2_bus.req_ready),     64'(0));
    chk("abort:resp_valid",   64'(l2_bus.resp_valid),    64'(0));
    chk("abort:resp_addr",    64'(l2_bus.resp_addr),     64'(0));
    chk("abort:resp_err",     64'(l2_bus.resp_err),      64'(0));
    chk_blk("abort:resp_data", l2_bus.resp_data, '0);
    chk("abort:mem_read",     64'(mem_bus.mem_read),     64'(0));
    chk("abort:mem_write",    64'(mem_bus.mem_write),    64'(0));
    chk("abort:mem_addr",     64'(mem_bus.mem_addr),     64'(0));
    chk_blk("abort:mem_data_out", mem_bus.mem_data_out, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort:req_ready_release", 64'(l2_bus.req_ready), 64'(1));
    quiet = 1'b1;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (l2_bus.resp_valid || mem_bus.mem_read || mem_bus.mem_write) quiet = 1'b0;
    end
    chk("abort:no_response", 64'(quiet), 64'(1));
    v = mk("after_rst", 32'h80, 0, 32'h0, 32'h0, HIT, 0, 32'h80, 32'h0, 0, LAT + 2);
    run_txn(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
